window3x3_gen: RTL and testbench

Streaming 3×3 neighbourhood generator that sits directly upstream of the vertical and horizontal edge detectors. It accepts a raster-order pixel stream of 10-bit intensities, buffers the previous two lines, and presents a packed 90-bit grid with a valid strobe for every pixel whose full 3×3 window lies inside the image. It also outputs the image coordinates of each window's centre pixel.

---
 rtl/vision_pkg.sv | 12 +
 rtl/window3x3_gen_if.sv | 20 ++
 rtl/window3x3_gen_line_buffer.sv | 20 ++
 rtl/window3x3_gen.sv | 101 ++++++++++
 tb/tb_window3x3_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/vision_pkg.sv
// Shared vision-pipeline constants and the 3x3 grid index helper.
package vision_pkg;
   localparam int DATA_W    = 10;
   localparam int GRID_W    = 9 * DATA_W;
   localparam int DEF_IMG_W = 640;
   localparam int DEF_IMG_H = 480;

   // Row r: 0 = current line, 2 = two lines up. Column c: 0 = newest pixel.
   function automatic int grid_idx(input int r, input int c);
      return 3 * r + c;
   endfunction
endpackage

// File: rtl/window3x3_gen_if.sv
// Pixel-in / window-out bundle for window3x3_gen; the source drives the master side.
interface window3x3_gen_if #(
   parameter int DATA_W = 10,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   logic                  iValid;
   logic                  iSof;
   logic [DATA_W-1:0]     iPixel;
   logic                  oValid;
   logic [9*DATA_W-1:0]   oGrid;
   logic [XW-1:0]         oX;
   logic [YW-1:0]         oY;

   modport master (output iValid, iSof, iPixel, input oValid, oGrid, oX, oY);
   modport slave  (input iValid, iSof, iPixel, output oValid, oGrid, oX, oY);
endinterface

// File: rtl/window3x3_gen_line_buffer.sv
// One-line pixel store: combinational read of the old word, written on accept.
module line_buffer #(
   parameter int  DEPTH = 640,
   parameter int  WIDTH = 10,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic [AW-1:0]    i_addr,
   input  logic             i_we,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge clock) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end
endmodule

// File: rtl/window3x3_gen.sv
// Raster-stream 3x3 neighbourhood generator with centre coordinates, 1-cycle latency.
module window3x3_gen
   import vision_pkg::*;
#(
   parameter int  DATA_W = vision_pkg::DATA_W,
   parameter int  IMG_W  = DEF_IMG_W,
   parameter int  IMG_H  = DEF_IMG_H,
   localparam int XW     = $clog2(IMG_W),
   localparam int YW     = $clog2(IMG_H),
   localparam int GW     = 9 * DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iValid,
   input  logic              iSof,
   input  logic [DATA_W-1:0] iPixel,
   output logic              oValid,
   output logic [GW-1:0]     oGrid,
   output logic [XW-1:0]     oX,
   output logic [YW-1:0]     oY
);
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic [DATA_W-1:0] r_win [9];

   logic [XW-1:0]     w_x, w_x_next;
   logic [YW-1:0]     w_y, w_y_next;
   logic              w_accept, w_hit;
   logic [DATA_W-1:0] w_col [3];
   logic [DATA_W-1:0] w_win_next [9];
   logic [GW-1:0]     w_grid_next;

   // A start-of-frame pixel is position (0,0) regardless of the counters.
   assign w_x      = iSof ? '0 : r_x;
   assign w_y      = iSof ? '0 : r_y;
   assign w_accept = iValid && !reset;
   assign w_hit    = w_accept && (w_x >= XW'(2)) && (w_y >= YW'(2));

   always_comb begin
      w_x_next = w_x + XW'(1);
      w_y_next = w_y;
      if (w_x == XW'(IMG_W - 1)) begin
         w_x_next = '0;
         w_y_next = (w_y == YW'(IMG_H - 1)) ? '0 : w_y + YW'(1);
      end
   end

   assign w_col[0] = iPixel;

   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
      .clock   (clock),
      .i_addr  (w_x),
      .i_we    (w_accept),
      .i_wdata (iPixel),
      .o_rdata (w_col[1])
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb2 (
      .clock   (clock),
      .i_addr  (w_x),
      .i_we    (w_accept),
      .i_wdata (w_col[1]),
      .o_rdata (w_col[2])
   );

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_row
         assign w_win_next[grid_idx(gi, 0)] = w_col[gi];
         assign w_win_next[grid_idx(gi, 1)] = r_win[grid_idx(gi, 0)];
         assign w_win_next[grid_idx(gi, 2)] = r_win[grid_idx(gi, 1)];
      end
      for (gi = 0; gi < 9; gi++) begin : g_pack
         assign w_grid_next[DATA_W*gi +: DATA_W] = w_win_next[gi];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         r_x    <= '0;
         r_y    <= '0;
         oValid <= 1'b0;
         oGrid  <= '0;
         oX     <= '0;
         oY     <= '0;
         for (int k = 0; k < 9; k++) r_win[k] <= '0;
      end else begin
         oValid <= w_hit;
         if (w_accept) begin
            r_x <= w_x_next;
            r_y <= w_y_next;
            for (int k = 0; k < 9; k++) r_win[k] <= w_win_next[k];
         end
         if (w_hit) begin
            oGrid <= w_grid_next;
            oX    <= w_x - XW'(1);
            oY    <= w_y - YW'(1);
         end
      end
   end
endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen on a 4x4 image: directed frames with literal checks plus random traffic vs a per-column history model.
module tb_window3x3_gen;
   localparam int DW = 10;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int GW = 9 * DW;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   window3x3_gen_if #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) bus ();

   window3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clock  (clock),
      .reset  (reset),
      .iValid (bus.iValid),
      .iSof   (bus.iSof),
      .iPixel (bus.iPixel),
      .oValid (bus.oValid),
      .oGrid  (bus.oGrid),
      .oX     (bus.oX),
      .oY     (bus.oY)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Model: the last three pixels accepted at each column, newest first.
   logic [DW-1:0] hist [W][3];
   int            mx = 0, my = 0;
   logic          pv = 1'b0;
   logic [GW-1:0] pg = '0;
   logic [1:0]    px = '0, py = '0;
   logic          exp_v = 1'b0;
   logic [GW-1:0] exp_g = '0;
   logic [1:0]    exp_x = '0, exp_y = '0;

   function automatic void chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
      end
   endfunction

   task automatic model(input bit v, input bit sof, input bit rst, input logic [DW-1:0] pix);
      if (rst) begin
         mx = 0; my = 0; pv = 0; pg = '0; px = '0; py = '0;
      end else if (v) begin
         if (sof) begin mx = 0; my = 0; end
         hist[mx][2] = hist[mx][1];
         hist[mx][1] = hist[mx][0];
         hist[mx][0] = pix;
         if (mx >= 2 && my >= 2) begin
            pv = 1;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  pg[DW*(3*r+c) +: DW] = hist[mx-c][r];
            px = 2'(mx - 1);
            py = 2'(my - 1);
         end else begin
            pv = 0;
         end
         mx++;
         if (mx == W) begin
            mx = 0;
            my++;
            if (my == H) my = 0;
         end
      end else begin
         pv = 0;
      end
   endtask

   // Drive one cycle; returns 1 time unit after the clock edge that consumed the inputs.
   task automatic step(input bit v, input bit sof, input bit rst, input logic [DW-1:0] pix);
      reset      = rst;
      bus.iValid = v;
      bus.iSof   = sof;
      bus.iPixel = pix;
      model(v, sof, rst, pix);
      @(posedge clock);
      #1;
      exp_v  = pv;
      exp_g  = pg;
      exp_x  = px;
      exp_y  = py;
      chk_en = 1'b1;
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("oValid", GW'(bus.oValid), GW'(exp_v));
         chk("oGrid", bus.oGrid, exp_g);
         chk("oX", GW'(bus.oX), GW'(exp_x));
         chk("oY", GW'(bus.oY), GW'(exp_y));
      end
   end

   task automatic run_frame(input bit toggle);
      int cnt;
      logic [GW-1:0] lit;
      cnt = 0;
      lit = {10'd0, 10'd1, 10'd2, 10'd16, 10'd17, 10'd18, 10'd32, 10'd33, 10'd34};
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            step(1'b1, (x == 0 && y == 0), 1'b0, DW'(16*y + x));
            chk("gate", GW'(bus.oValid), GW'(x >= 2 && y >= 2));
            if (bus.oValid === 1'b1) cnt++;
            if (x == 2 && y == 2) begin
               chk("first_grid", bus.oGrid, lit);
               chk("first_x", GW'(bus.oX), GW'(1));
               chk("first_y", GW'(bus.oY), GW'(1));
            end
            if (toggle) begin
               step(1'b0, 1'b0, 1'b0, DW'($urandom));
               chk("idle_valid", GW'(bus.oValid), GW'(0));
            end
         end
      end
      chk("strobes", GW'(cnt), GW'(4));
   endtask

   // Streams pixels until the first strobe; returns the stream index of that pixel or -1.
   task automatic first_strobe(output int idx);
      idx = -1;
      for (int i = 1; i <= 30; i++) begin
         step(1'b1, 1'b0, 1'b0, DW'($urandom));
         if (bus.oValid === 1'b1) begin
            idx = i;
            break;
         end
      end
   endtask

   initial begin
      int idx;
      bus.iValid = 1'b0;
      bus.iSof   = 1'b0;
      bus.iPixel = '0;
      for (int c = 0; c < W; c++)
         for (int r = 0; r < 3; r++) hist[c][r] = '0;

      step(1'b0, 1'b0, 1'b1, '0);
      step(1'b0, 1'b0, 1'b1, '0);
      chk("rst_valid", GW'(bus.oValid), GW'(0));
      chk("rst_grid", bus.oGrid, GW'(0));

      run_frame(1'b0);
      run_frame(1'b0);
      run_frame(1'b1);

      // Mid-frame resync: iSof arrives at frame position (1,2).
      for (int i = 0; i < 9; i++) step(1'b1, (i == 0), 1'b0, DW'(i));
      step(1'b1, 1'b1, 1'b0, DW'(99));
      first_strobe(idx);
      chk("sof_resync_idx", GW'(idx), GW'(10));

      // Reset without and with a valid pixel, then restart without iSof.
      step(1'b0, 1'b0, 1'b1, '0);
      chk("rst_mid_grid", bus.oGrid, GW'(0));
      chk("rst_mid_x", GW'(bus.oX), GW'(0));
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom));
      step(1'b1, 1'b0, 1'b1, DW'(777));
      chk("rst_valid_pix", GW'(bus.oValid), GW'(0));
      chk("rst_valid_grid", bus.oGrid, GW'(0));
      step(1'b1, 1'b0, 1'b0, DW'($urandom));
      first_strobe(idx);
      chk("rst_restart_idx", GW'(idx), GW'(10));

      // Random traffic: gaps, sporadic iSof and occasional reset.
      step(1'b1, 1'b1, 1'b0, DW'($urandom));
      for (int i = 0; i < 3000; i++) begin
         bit v, s, r;
         v = ($urandom_range(0, 3) != 0);
         s = v && ($urandom_range(0, 99) == 0);
         r = ($urandom_range(0, 399) == 0);
         step(v, s, r, DW'($urandom));
      end
      step(1'b0, 1'b0, 1'b0, '0);
      @(posedge clock);
      #1;
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
